// File: rtl/controller_sequencer_if.sv
// Datapath-side signals of the controller sequencer: IR/flag inputs and all control strobes.
interface controller_sequencer_if;
  logic [7:0] instruction;
  logic       zero_flag;
  logic       carry_flag;
  logic       count_pc;
  logic       load_pc;
  logic       enable_pc;
  logic       load_mar;
  logic       ce_ram;
  logic       we_ram;
  logic       load_mdr_reg;
  logic       enable_mdr_reg;
  logic       flip_flop;
  logic       load_accum;
  logic       enable_accum;
  logic       load_b_reg;
  logic       load_c_reg;
  logic       load_temp_reg;
  logic       enable_alu;
  logic       sub_mode;
  logic       load_inst_reg;
  logic       clear_inst_reg;
  logic       load_output_reg;
  logic       enable_input;
  logic       halted;

  modport master (
    input  instruction, zero_flag, carry_flag,
    output count_pc, load_pc, enable_pc, load_mar, ce_ram, we_ram,
           load_mdr_reg, enable_mdr_reg, flip_flop, load_accum, enable_accum,
           load_b_reg, load_c_reg, load_temp_reg, enable_alu, sub_mode,
           load_inst_reg, clear_inst_reg, load_output_reg, enable_input, halted
  );

  modport slave (
    output instruction, zero_flag, carry_flag,
    input  count_pc, load_pc, enable_pc, load_mar, ce_ram, we_ram,
           load_mdr_reg, enable_mdr_reg, flip_flop, load_accum, enable_accum,
           load_b_reg, load_c_reg, load_temp_reg, enable_alu, sub_mode,
           load_inst_reg, clear_inst_reg, load_output_reg, enable_input, halted
  );
endinterface

// File: rtl/controller_sequencer.sv
// Fetch/decode/execute control FSM for the 8-bit bus CPU.
// Optional CTRL_COND_JUMP_EN: enables JZ/JC and the Z/C flag latches.
module controller_sequencer (
  input  logic                          clk,
  input  logic                          clear,
  controller_sequencer_if.master        bus
);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_MVB = 4'h5;
  localparam logic [3:0] OP_MVC = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_JC  = 4'h9;
  localparam logic [3:0] OP_IN  = 4'hA;
  localparam logic [3:0] OP_OUT = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [3:0] {
    S_F0, S_F1, S_F2, S_F3, S_D0,
    S_O0, S_O1, S_O2, S_O3,
    S_E0, S_E1, S_E2, S_E3,
    S_HALT
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] opcode;
  logic       unused_operand_bits;
  logic       two_byte;
  logic       z_q;
  logic       c_q;

  assign opcode              = bus.instruction[7:4];
  assign unused_operand_bits = ^bus.instruction[3:0];
  assign two_byte            = (opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA,
                                               OP_JMP, OP_JZ, OP_JC});
  assign bus.clear_inst_reg  = clear;

  always_ff @(posedge clk) begin
    if (clear) state <= S_F0;
    else       state <= state_next;
  end

`ifdef CTRL_COND_JUMP_EN
  // Flags only move on the ALU write-back cycle of ADD/SUB.
  always_ff @(posedge clk) begin
    if (clear) begin
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else if (state == S_E3) begin
      z_q <= bus.zero_flag;
      c_q <= bus.carry_flag;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = bus.zero_flag ^ bus.carry_flag;
  assign z_q = 1'b0;
  assign c_q = 1'b0;
`endif

  // Next state and Moore control decode; clear forces every strobe low.
  always_comb begin
    state_next          = state;
    bus.count_pc        = 1'b0;
    bus.load_pc         = 1'b0;
    bus.enable_pc       = 1'b0;
    bus.load_mar        = 1'b0;
    bus.ce_ram          = 1'b0;
    bus.we_ram          = 1'b0;
    bus.load_mdr_reg    = 1'b0;
    bus.enable_mdr_reg  = 1'b0;
    bus.flip_flop       = 1'b0;
    bus.load_accum      = 1'b0;
    bus.enable_accum    = 1'b0;
    bus.load_b_reg      = 1'b0;
    bus.load_c_reg      = 1'b0;
    bus.load_temp_reg   = 1'b0;
    bus.enable_alu      = 1'b0;
    bus.sub_mode        = 1'b0;
    bus.load_inst_reg   = 1'b0;
    bus.load_output_reg = 1'b0;
    bus.enable_input    = 1'b0;
    bus.halted          = 1'b0;
    if (!clear) begin
      unique case (state)
        S_F0, S_O0: begin
          bus.enable_pc = 1'b1;
          bus.load_mar  = 1'b1;
          state_next    = (state == S_F0) ? S_F1 : S_O1;
        end
        S_F1, S_O1: begin
          bus.ce_ram   = 1'b1;
          bus.count_pc = 1'b1;
          state_next   = (state == S_F1) ? S_F2 : S_O2;
        end
        S_F2, S_O2: begin
          bus.ce_ram       = 1'b1;
          bus.load_mdr_reg = 1'b1;
          state_next       = (state == S_F2) ? S_F3 : S_O3;
        end
        S_F3: begin
          bus.enable_mdr_reg = 1'b1;
          bus.load_inst_reg  = 1'b1;
          state_next         = S_D0;
        end
        S_D0: begin
          if (two_byte)                 state_next = S_O0;
          else if (opcode == OP_HLT)    state_next = S_HALT;
          else if (opcode inside {OP_MVB, OP_MVC, OP_IN, OP_OUT})
                                        state_next = S_E0;
          else                          state_next = S_F0;
        end
        S_O3: begin
          bus.enable_mdr_reg = 1'b1;
          state_next         = S_F0;
          if (opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA}) begin
            bus.load_mar = 1'b1;
            state_next   = S_E0;
          end else if (opcode == OP_JMP) begin
            bus.load_pc = 1'b1;
          end else if (opcode == OP_JZ) begin
            bus.load_pc = z_q;
          end else if (opcode == OP_JC) begin
            bus.load_pc = c_q;
          end
        end
        S_E0: begin
          state_next = S_F0;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              bus.ce_ram = 1'b1;
              state_next = S_E1;
            end
            OP_STA: begin
              bus.enable_accum = 1'b1;
              bus.load_mdr_reg = 1'b1;
              bus.flip_flop    = 1'b1;
              state_next       = S_E1;
            end
            OP_MVB: begin
              bus.enable_accum = 1'b1;
              bus.load_b_reg   = 1'b1;
            end
            OP_MVC: begin
              bus.enable_accum = 1'b1;
              bus.load_c_reg   = 1'b1;
            end
            OP_OUT: begin
              bus.enable_accum    = 1'b1;
              bus.load_output_reg = 1'b1;
            end
            OP_IN: begin
              bus.enable_input = 1'b1;
              bus.load_accum   = 1'b1;
            end
            default: ;
          endcase
        end
        S_E1: begin
          state_next = S_F0;
          if (opcode inside {OP_LDA, OP_ADD, OP_SUB}) begin
            bus.ce_ram       = 1'b1;
            bus.load_mdr_reg = 1'b1;
            state_next       = S_E2;
          end else if (opcode == OP_STA) begin
            bus.ce_ram = 1'b1;
            bus.we_ram = 1'b1;
          end
        end
        S_E2: begin
          state_next = S_F0;
          if (opcode == OP_LDA) begin
            bus.enable_mdr_reg = 1'b1;
            bus.load_accum     = 1'b1;
          end else if (opcode inside {OP_ADD, OP_SUB}) begin
            bus.enable_mdr_reg = 1'b1;
            bus.load_temp_reg  = 1'b1;
            state_next         = S_E3;
          end
        end
        S_E3: begin
          bus.enable_alu = 1'b1;
          bus.load_accum = 1'b1;
          bus.sub_mode   = (opcode == OP_SUB);
          state_next     = S_F0;
        end
        S_HALT: begin
          bus.halted = 1'b1;
        end
        default: state_next = S_F0;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed vector bench for controller_sequencer, plus a random invariant sweep.
module tb_controller_sequencer;

  logic clk;
  logic clear;

  controller_sequencer_if bus ();

  controller_sequencer dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [20:0] CPC  = 21'(1) << 20;
  localparam logic [20:0] LPC  = 21'(1) << 19;
  localparam logic [20:0] EPC  = 21'(1) << 18;
  localparam logic [20:0] LMAR = 21'(1) << 17;
  localparam logic [20:0] CE   = 21'(1) << 16;
  localparam logic [20:0] WE   = 21'(1) << 15;
  localparam logic [20:0] LMDR = 21'(1) << 14;
  localparam logic [20:0] EMDR = 21'(1) << 13;
  localparam logic [20:0] FF   = 21'(1) << 12;
  localparam logic [20:0] LACC = 21'(1) << 11;
  localparam logic [20:0] EACC = 21'(1) << 10;
  localparam logic [20:0] LB   = 21'(1) << 9;
  localparam logic [20:0] LC   = 21'(1) << 8;
  localparam logic [20:0] LTMP = 21'(1) << 7;
  localparam logic [20:0] EALU = 21'(1) << 6;
  localparam logic [20:0] SUBM = 21'(1) << 5;
  localparam logic [20:0] LIR  = 21'(1) << 4;
  localparam logic [20:0] CLR  = 21'(1) << 3;
  localparam logic [20:0] LOUT = 21'(1) << 2;
  localparam logic [20:0] EIN  = 21'(1) << 1;
  localparam logic [20:0] HLT  = 21'(1) << 0;

`ifdef CTRL_COND_JUMP_EN
  localparam logic [20:0] COND_LPC = LPC;
`else
  localparam logic [20:0] COND_LPC = 21'(0);
`endif

  typedef struct {
    logic        clr;
    logic [7:0]  ins;
    logic        z;
    logic        c;
    logic [20:0] exp;
    string       tag;
  } vec_t;

  vec_t vq[$];
  int   n_vec;
  int   n_bad;

  function automatic logic [20:0] observed();
    return {bus.count_pc, bus.load_pc, bus.enable_pc, bus.load_mar, bus.ce_ram,
            bus.we_ram, bus.load_mdr_reg, bus.enable_mdr_reg, bus.flip_flop,
            bus.load_accum, bus.enable_accum, bus.load_b_reg, bus.load_c_reg,
            bus.load_temp_reg, bus.enable_alu, bus.sub_mode, bus.load_inst_reg,
            bus.clear_inst_reg, bus.load_output_reg, bus.enable_input, bus.halted};
  endfunction

  task automatic push(input logic clr, input logic [7:0] ins, input logic z,
                      input logic c, input logic [20:0] e, input string tag);
    vec_t v;
    v.clr = clr; v.ins = ins; v.z = z; v.c = c; v.exp = e; v.tag = tag;
    vq.push_back(v);
  endtask

  // F0..F3 plus the silent decode cycle.
  task automatic fetch(input logic [7:0] ins, input logic f, input string tag);
    push(1'b0, ins, f, f, EPC | LMAR, {tag, ".F0"});
    push(1'b0, ins, f, f, CE | CPC,   {tag, ".F1"});
    push(1'b0, ins, f, f, CE | LMDR,  {tag, ".F2"});
    push(1'b0, ins, f, f, EMDR | LIR, {tag, ".F3"});
    push(1'b0, ins, f, f, 21'(0),     {tag, ".D0"});
  endtask

  task automatic operand(input logic [7:0] ins, input logic f,
                         input logic [20:0] o3, input string tag);
    push(1'b0, ins, f, f, EPC | LMAR, {tag, ".O0"});
    push(1'b0, ins, f, f, CE | CPC,   {tag, ".O1"});
    push(1'b0, ins, f, f, CE | LMDR,  {tag, ".O2"});
    push(1'b0, ins, f, f, EMDR | o3,  {tag, ".O3"});
  endtask

  task automatic add_sub(input logic [7:0] ins, input logic f_pre,
                         input logic zf, input logic cf, input string tag);
    fetch(ins, f_pre, tag);
    operand(ins, f_pre, LMAR, tag);
    push(1'b0, ins, f_pre, f_pre, CE,          {tag, ".E0"});
    push(1'b0, ins, f_pre, f_pre, CE | LMDR,   {tag, ".E1"});
    push(1'b0, ins, f_pre, f_pre, EMDR | LTMP, {tag, ".E2"});
    push(1'b0, ins, zf, cf,
         (ins[7:4] == 4'h3) ? (EALU | LACC | SUBM) : (EALU | LACC), {tag, ".E3"});
  endtask

  task automatic build_table();
    push(1'b1, 8'h00, 1'b0, 1'b0, CLR, "rst0");
    push(1'b1, 8'h00, 1'b0, 1'b0, CLR, "rst1");
    fetch(8'h10, 1'b0, "lda");
    operand(8'h10, 1'b0, LMAR, "lda");
    push(1'b0, 8'h10, 1'b0, 1'b0, CE,          "lda.E0");
    push(1'b0, 8'h10, 1'b0, 1'b0, CE | LMDR,   "lda.E1");
    push(1'b0, 8'h10, 1'b0, 1'b0, EMDR | LACC, "lda.E2");
    add_sub(8'h21, 1'b0, 1'b1, 1'b1, "add");
    fetch(8'hB0, 1'b0, "out");
    push(1'b0, 8'hB0, 1'b0, 1'b0, EACC | LOUT, "out.E0");
    fetch(8'h80, 1'b0, "jz_t");
    operand(8'h80, 1'b0, COND_LPC, "jz_t");
    fetch(8'h90, 1'b0, "jc_t");
    operand(8'h90, 1'b0, COND_LPC, "jc_t");
    add_sub(8'h31, 1'b1, 1'b0, 1'b0, "sub");
    fetch(8'h80, 1'b1, "jz_n");
    operand(8'h80, 1'b1, 21'(0), "jz_n");
    fetch(8'h90, 1'b1, "jc_n");
    operand(8'h90, 1'b1, 21'(0), "jc_n");
    fetch(8'h70, 1'b0, "jmp");
    operand(8'h70, 1'b0, LPC, "jmp");
    fetch(8'h40, 1'b0, "sta");
    operand(8'h40, 1'b0, LMAR, "sta");
    push(1'b0, 8'h40, 1'b0, 1'b0, EACC | LMDR | FF, "sta.E0");
    push(1'b0, 8'h40, 1'b0, 1'b0, CE | WE,          "sta.E1");
    fetch(8'h50, 1'b0, "mvb");
    push(1'b0, 8'h50, 1'b0, 1'b0, EACC | LB, "mvb.E0");
    fetch(8'h60, 1'b0, "mvc");
    push(1'b0, 8'h60, 1'b0, 1'b0, EACC | LC, "mvc.E0");
    fetch(8'hA0, 1'b0, "in");
    push(1'b0, 8'hA0, 1'b0, 1'b0, EIN | LACC, "in.E0");
    fetch(8'h00, 1'b0, "nop");
    fetch(8'hD5, 1'b0, "nopD");
    add_sub(8'h21, 1'b0, 1'b1, 1'b1, "add2");
    // Abort an ADD at E1: flags set above must be wiped by clear.
    fetch(8'h22, 1'b0, "addx");
    operand(8'h22, 1'b0, LMAR, "addx");
    push(1'b0, 8'h22, 1'b0, 1'b0, CE,  "addx.E0");
    push(1'b1, 8'h22, 1'b1, 1'b1, CLR, "addx.clr0");
    push(1'b1, 8'h22, 1'b1, 1'b1, CLR, "addx.clr1");
    fetch(8'h90, 1'b0, "jc_clr");
    operand(8'h90, 1'b0, 21'(0), "jc_clr");
    fetch(8'h80, 1'b0, "jz_clr");
    operand(8'h80, 1'b0, 21'(0), "jz_clr");
    fetch(8'hF0, 1'b0, "hlt");
    for (int i = 0; i < 20; i++) push(1'b0, 8'hF0, 1'b1, 1'b1, HLT, "halt");
    push(1'b1, 8'hF0, 1'b0, 1'b0, CLR, "halt.clr");
    fetch(8'h00, 1'b0, "restart");
  endtask

  initial begin
    logic [20:0] got;
    n_vec = 0;
    n_bad = 0;
    clear           = 1'b1;
    bus.instruction = 8'h00;
    bus.zero_flag   = 1'b0;
    bus.carry_flag  = 1'b0;
    build_table();

    foreach (vq[i]) begin
      @(negedge clk);
      clear           = vq[i].clr;
      bus.instruction = vq[i].ins;
      bus.zero_flag   = vq[i].z;
      bus.carry_flag  = vq[i].c;
      #1;
      got = observed();
      n_vec++;
      if (got !== vq[i].exp) begin
        n_bad++;
        $display("FAIL %s (vec %0d): controls got %h, expected %h",
                 vq[i].tag, i, got, vq[i].exp);
      end
    end

    // Random sweep: bus exclusivity, write strobe and jump-load sanity.
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] drv;
      logic       ok;
      @(negedge clk);
      clear           = ($urandom_range(0, 63) == 0);
      bus.instruction = 8'($urandom);
      bus.zero_flag   = 1'($urandom);
      bus.carry_flag  = 1'($urandom);
      #1;
      drv = {bus.enable_pc, bus.enable_accum, bus.enable_alu,
             bus.enable_mdr_reg, bus.enable_input};
      ok = $onehot0(drv) && !(bus.we_ram && !bus.ce_ram);
`ifdef CTRL_COND_JUMP_EN
      if (bus.load_pc && !(bus.instruction[7:4] inside {4'h7, 4'h8, 4'h9})) ok = 1'b0;
`else
      if (bus.load_pc && (bus.instruction[7:4] != 4'h7)) ok = 1'b0;
`endif
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL invariant (cycle %0d): enables %b we %b ce %b load_pc %b op %h, expected legal",
                 i, drv, bus.we_ram, bus.ce_ram, bus.load_pc, bus.instruction[7:4]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
